rf_wb_queue: RTL and testbench

//  Write-back queue that drives the register-file write port (RegWr/W_Reg/W_data).

---
 rtl/rf_wb_queue_if.sv | 41 ++++
 rtl/rf_wb_queue.sv | 93 +++++++++
 tb/tb_rf_wb_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_queue_if.sv
// Bundle between the write-back producers / RF write port / decode lookups
// and the write-back queue.
interface rf_wb_queue_if #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // producer side
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_WIDTH-1:0]  wb_reg;
  logic [WORD_WIDTH-1:0] wb_data;
  // register-file write port
  logic                  rf_grant;
  logic                  RegWr;
  logic [REG_WIDTH-1:0]  W_Reg;
  logic [WORD_WIDTH-1:0] W_data;
  // forwarding lookups
  logic [REG_WIDTH-1:0]  fwd_reg1;
  logic                  fwd_hit1;
  logic [WORD_WIDTH-1:0] fwd_data1;
  logic [REG_WIDTH-1:0]  fwd_reg2;
  logic                  fwd_hit2;
  logic [WORD_WIDTH-1:0] fwd_data2;
  // occupancy
  logic [CW-1:0]         count;

  modport master (
    output wb_valid, wb_reg, wb_data, rf_grant, fwd_reg1, fwd_reg2,
    input  wb_ready, RegWr, W_Reg, W_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, rf_grant, fwd_reg1, fwd_reg2,
    output wb_ready, RegWr, W_Reg, W_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Write-back queue feeding the register-file write port. Results are held in
// a circular buffer, retired one per granted cycle in FIFO order, and exposed
// to decode through two forwarding lookups (youngest pending value wins).
module rf_wb_queue #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DEPTH      = 4
) (
  input  logic         CLK,
  input  logic         RST_n,
  rf_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [REG_WIDTH-1:0]  reg_q  [DEPTH];
  logic [WORD_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic full, empty, push, store, pop;

  // Handshake qualifiers and next-state pointer/occupancy values
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    push     = bus.wb_valid & ~full;
    store    = push & (bus.wb_reg != '0);
    pop      = ~empty & bus.rf_grant;
    wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(store) - CW'(pop);
  end

  // Pointer, occupancy and entry storage registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // store and pop never target the same slot: store is refused when full
      if (pop) vld_q[rd_ptr_q] <= 1'b0;
      if (store) begin
        reg_q[wr_ptr_q]  <= bus.wb_reg;
        data_q[wr_ptr_q] <= bus.wb_data;
        vld_q[wr_ptr_q]  <= 1'b1;
      end
    end
  end

  // Head entry drives the RF write port; zeroed while empty
  always_comb begin
    bus.wb_ready = ~full;
    bus.count    = count_q;
    bus.RegWr    = ~empty;
    bus.W_Reg    = empty ? '0 : reg_q[rd_ptr_q];
    bus.W_data   = empty ? '0 : data_q[rd_ptr_q];
  end

  // Forwarding: walk oldest to youngest from the head so the last match is the
  // youngest pending write, which handles pointer wrap without a priority encoder
  always_comb begin
    logic [AW-1:0] idx;
    idx           = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (vld_q[idx] && (bus.fwd_reg1 != '0) && (reg_q[idx] == bus.fwd_reg1)) begin
        bus.fwd_hit1  = 1'b1;
        bus.fwd_data1 = data_q[idx];
      end
      if (vld_q[idx] && (bus.fwd_reg2 != '0) && (reg_q[idx] == bus.fwd_reg2)) begin
        bus.fwd_hit2  = 1'b1;
        bus.fwd_data2 = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios plus randomized traffic against a
// queue-based reference model; retirements are checked by a separate monitor
// against a scoreboard of expected RF writes.
module tb_rf_wb_queue;
  localparam int WW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [RW-1:0] r;
    logic [WW-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;

  rf_wb_queue_if #(.WORD_WIDTH(WW), .REG_WIDTH(RW), .DEPTH(DEPTH)) bus ();

  rf_wb_queue #(.WORD_WIDTH(WW), .REG_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .RST_n(rst_n),
    .bus  (bus)
  );

  ent_t pend[$];   // reference model: pending writes, oldest first
  ent_t exp_q[$];  // scoreboard: RF writes expected, in order

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare combinational outputs against the
  // model, then advance the model as the coming clock edge will.
  task automatic step(input bit v, input logic [RW-1:0] r, input logic [WW-1:0] d,
                      input bit g, input logic [RW-1:0] f1, input logic [RW-1:0] f2);
    int n;
    bit h1, h2, rdy, wr;
    logic [WW-1:0] d1, d2;
    ent_t e;
    @(negedge clk);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
    bus.rf_grant = g;
    bus.fwd_reg1 = f1;
    bus.fwd_reg2 = f2;
    #1;
    n   = pend.size();
    rdy = (n < DEPTH);
    wr  = (n > 0);
    h1 = 0; d1 = '0; h2 = 0; d2 = '0;
    for (int j = n - 1; j >= 0; j--) begin
      if (!h1 && f1 != 0 && pend[j].r == f1) begin h1 = 1; d1 = pend[j].d; end
      if (!h2 && f2 != 0 && pend[j].r == f2) begin h2 = 1; d2 = pend[j].d; end
    end
    chk("count",     WW'(bus.count), WW'(n));
    chk("wb_ready",  WW'(bus.wb_ready), WW'(rdy));
    chk("RegWr",     WW'(bus.RegWr), WW'(wr));
    chk("W_Reg",     WW'(bus.W_Reg), wr ? WW'(pend[0].r) : '0);
    chk("W_data",    bus.W_data, wr ? pend[0].d : '0);
    chk("fwd_hit1",  WW'(bus.fwd_hit1), WW'(h1));
    chk("fwd_data1", bus.fwd_data1, d1);
    chk("fwd_hit2",  WW'(bus.fwd_hit2), WW'(h2));
    chk("fwd_data2", bus.fwd_data2, d2);
    if (wr && g) void'(pend.pop_front());
    if (v && rdy && r != 0) begin
      e.r = r;
      e.d = d;
      pend.push_back(e);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input logic [RW-1:0] f1);
    for (int k = 0; k < 20 && pend.size() > 0; k++) step(0, 0, 0, 1, f1, 0);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_count",    WW'(bus.count), 0);
    chk("rst_RegWr",    WW'(bus.RegWr), 0);
    chk("rst_wb_ready", WW'(bus.wb_ready), 1);
    chk("rst_hit1",     WW'(bus.fwd_hit1), 0);
    chk("rst_hit2",     WW'(bus.fwd_hit2), 0);
    chk("rst_data1",    bus.fwd_data1, 0);
    chk("rst_W_data",   bus.W_data, 0);
    pend.delete();
    exp_q.delete();
    bus.wb_valid = 0;
    bus.rf_grant = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every granted RF write must match the next scoreboard entry
  always begin
    ent_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.RegWr && bus.rf_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retire_unexpected: got reg %0d data 0x%0h expected no write at %0t",
                 bus.W_Reg, bus.W_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("retire_reg",  WW'(bus.W_Reg), WW'(e.r));
        chk("retire_data", bus.W_data, e.d);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.wb_valid = 0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
    bus.rf_grant = 0;
    bus.fwd_reg1 = '0;
    bus.fwd_reg2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_count",    WW'(bus.count), 0);
    chk("init_wb_ready", WW'(bus.wb_ready), 1);
    chk("init_RegWr",    WW'(bus.RegWr), 0);
    rst_n = 1'b1;

    // Single push retires the following cycle
    step(1, 5, 32'h1234, 1, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    chk("t2_RegWr",  WW'(bus.RegWr), 1);
    chk("t2_W_Reg",  WW'(bus.W_Reg), 5);
    chk("t2_W_data", bus.W_data, 32'h1234);
    chk("t2_hit1",   WW'(bus.fwd_hit1), 1);
    step(0, 0, 0, 1, 5, 0);
    chk("t2_RegWr_after", WW'(bus.RegWr), 0);

    // Fill to full, stall, pop+push while full is refused
    for (int i = 1; i <= 4; i++) step(1, RW'(i), WW'(32'h100 + i), 0, 0, 0);
    step(1, 9, 32'h999, 0, 3, 4);
    chk("t3_ready_full", WW'(bus.wb_ready), 0);
    chk("t3_count_full", WW'(bus.count), 4);
    step(1, 10, 32'hAAA, 1, 1, 2);
    chk("t3_ready_popfull", WW'(bus.wb_ready), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_count_after", WW'(bus.count), 3);
    drain(0);

    // Two pending writes to the same register: youngest forwards
    step(1, 7, 32'hA, 0, 0, 0);
    step(1, 7, 32'hB, 0, 7, 0);
    step(0, 0, 0, 0, 7, 0);
    chk("t4_hit1",  WW'(bus.fwd_hit1), 1);
    chk("t4_data1", bus.fwd_data1, 32'hB);
    chk("t4_hit2",  WW'(bus.fwd_hit2), 0);
    drain(7);
    step(0, 0, 0, 1, 7, 7);
    chk("t4_hit1_retired", WW'(bus.fwd_hit1), 0);

    // Writes to register 0 complete the handshake but store nothing
    step(1, 0, 32'hFFFF, 0, 0, 0);
    chk("t5_ready", WW'(bus.wb_ready), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_count", WW'(bus.count), 0);
    chk("t5_RegWr", WW'(bus.RegWr), 0);

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) step(1, RW'(i + 11), WW'(32'h50 + i), 0, 12, 0);
    step(0, 0, 0, 0, 12, 13);
    chk("t1_count_pre", WW'(bus.count), 3);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 9) < 6,
           RW'($urandom_range(0, 7)),
           $urandom,
           $urandom_range(0, 1) == 1,
           RW'($urandom_range(0, 7)),
           RW'($urandom_range(0, 7)));
    end
    drain(0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", WW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
